// File: rtl/fractional_interpolator.sv
// Polyphase 3/2 fractional rate converter with serial coefficient load.
// Define FRAC_INTERP_CONV_ROUND_EN for convergent rounding.
module fractional_interpolator #(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_FRAC   = 15,
   parameter int COEFF_WIDTH = 20,
   parameter int COEFF_FRAC  = 18,
   parameter int L           = 3,
   parameter int M           = 2,
   parameter int N_TAP       = 72
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   output logic                          ready_in,
   input  logic signed [DATA_WIDTH-1:0]  filter_in,
   input  logic                          coeff_wr_en,
   input  logic [$clog2(N_TAP)-1:0]      coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_data,
   output logic signed [DATA_WIDTH-1:0]  filter_out,
   output logic                          valid_out,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PH         = N_TAP / L;
   localparam int AW         = $clog2(N_TAP);
   localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
   localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(PH);
   localparam int ACC_FRAC   = DATA_FRAC + COEFF_FRAC;
   localparam int SHIFT      = ACC_FRAC - DATA_FRAC;

   localparam logic signed [DATA_WIDTH-1:0] OMAX =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] OMIN =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] HALF =
      ACC_WIDTH'(1) <<< (SHIFT - 1);

   typedef enum logic {S_WAIT, S_EMIT} state_e;

   state_e      state_q, state_d;
   logic [1:0]  out_idx_q, out_idx_d;
   logic [1:0]  ph;
   logic        shift_en, emit_en;

   logic signed [DATA_WIDTH-1:0] fo_q, fo_d;
   logic        vo_q, ov_q, un_q, ov_d, un_d;
   logic signed [ACC_WIDTH-1:0]  acc, sh;

   // Phase visited by each output slot is (out_idx * M) mod L.
   always_comb begin
      ph = 2'd0;
      unique case (out_idx_q)
         2'd0:    ph = 2'd0;
         2'd1:    ph = 2'(M % L);
         default: ph = 2'((2 * M) % L);
      endcase
   end

   for (genvar j = 0; j < PH; j++) begin : g_tap
      localparam logic [AW-1:0] A0 = AW'(j * L);
      localparam logic [AW-1:0] A1 = AW'(j * L + 1);
      localparam logic [AW-1:0] A2 = AW'(j * L + 2);

      logic signed [DATA_WIDTH-1:0]  dl_q;
      logic signed [COEFF_WIDTH-1:0] c0_q, c1_q, c2_q, cf;
      logic signed [PROD_WIDTH-1:0]  prod;
      logic signed [ACC_WIDTH-1:0]   sum;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
         end else if (coeff_wr_en) begin
            if (coeff_addr == A0) c0_q <= coeff_data;
            if (coeff_addr == A1) c1_q <= coeff_data;
            if (coeff_addr == A2) c2_q <= coeff_data;
         end
      end

      if (j == 0) begin : g_head
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           dl_q <= '0;
            else if (coeff_wr_en) dl_q <= '0;
            else if (shift_en)    dl_q <= filter_in;
         end
      end else begin : g_body
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           dl_q <= '0;
            else if (coeff_wr_en) dl_q <= '0;
            else if (shift_en)    dl_q <= g_tap[j-1].dl_q;
         end
      end

      assign cf   = (ph == 2'd0) ? c0_q :
                    (ph == 2'd1) ? c1_q : c2_q;
      assign prod = dl_q * cf;

      if (j == 0) begin : g_s0
         assign sum = ACC_WIDTH'(prod);
      end else begin : g_sn
         assign sum = g_tap[j-1].sum + ACC_WIDTH'(prod);
      end
   end

   assign acc = g_tap[PH-1].sum;

`ifdef FRAC_INTERP_CONV_ROUND_EN
   localparam logic [SHIFT-1:0] HALF_F = {1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] ONE = 1;
   logic signed [ACC_WIDTH-1:0] trunc;
   logic [SHIFT-1:0]            frac;

   always_comb begin
      trunc = acc >>> SHIFT;
      frac  = acc[SHIFT-1:0];
      sh    = trunc;
      if (frac > HALF_F || (frac == HALF_F && trunc[0]))
         sh = trunc + ONE;
   end
`else
   assign sh = (acc + HALF) >>> SHIFT;
`endif

   always_comb begin
      ov_d = sh > ACC_WIDTH'(OMAX);
      un_d = sh < ACC_WIDTH'(OMIN);
      fo_d = sh[DATA_WIDTH-1:0];
      if (ov_d) fo_d = OMAX;
      if (un_d) fo_d = OMIN;
   end

   always_comb begin
      state_d   = state_q;
      out_idx_d = out_idx_q;
      shift_en  = 1'b0;
      emit_en   = 1'b0;
      ready_in  = 1'b0;
      if (coeff_wr_en) begin
         state_d   = S_WAIT;
         out_idx_d = 2'd0;
      end else begin
         unique case (state_q)
            S_WAIT: begin
               ready_in = 1'b1;
               if (valid_in) begin
                  shift_en = 1'b1;
                  state_d  = S_EMIT;
               end
            end
            default: begin
               emit_en   = 1'b1;
               out_idx_d = (out_idx_q == 2'd2) ? 2'd0 : out_idx_q + 2'd1;
               state_d   = (out_idx_d == 2'd1) ? S_EMIT : S_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_WAIT;
         out_idx_q <= 2'd0;
         fo_q      <= '0;
         vo_q      <= 1'b0;
         ov_q      <= 1'b0;
         un_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_idx_q <= out_idx_d;
         vo_q      <= emit_en;
         ov_q      <= emit_en & ov_d;
         un_q      <= emit_en & un_d;
         if (coeff_wr_en)  fo_q <= '0;
         else if (emit_en) fo_q <= fo_d;
      end
   end

   assign filter_out = fo_q;
   assign valid_out  = vo_q;
   assign overflow   = ov_q;
   assign underflow  = un_q;

endmodule

// File: tb/tb_fractional_interpolator.sv
// Directed bench for fractional_interpolator: vector table plus
// impulse, rate, abort and reset sequences.
module tb_fractional_interpolator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [15:0] filter_in = '0;
   logic        coeff_wr_en = 1'b0;
   logic [6:0]  coeff_addr = '0;
   logic [19:0] coeff_data = '0;
   logic [15:0] filter_out;
   logic        valid_out, overflow, underflow;

   int total = 0;
   int bad   = 0;

   fractional_interpolator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .filter_in   (filter_in),
      .coeff_wr_en (coeff_wr_en),
      .coeff_addr  (coeff_addr),
      .coeff_data  (coeff_data),
      .filter_out  (filter_out),
      .valid_out   (valid_out),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] h0, h1, h2;
      logic [15:0] x, e0, e1;
      logic        ov, un;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [19:0] d);
      @(negedge clk);
      coeff_wr_en = 1'b1;
      coeff_addr  = a;
      coeff_data  = d;
      @(negedge clk);
      coeff_wr_en = 1'b0;
   endtask

   task automatic send(input logic [15:0] x);
      int n = 0;
      @(negedge clk);
      while (!ready_in && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready_in) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got ready_in=0 want 1");
      end else begin
         valid_in  = 1'b1;
         filter_in = x;
         @(negedge clk);
         valid_in  = 1'b0;
      end
   endtask

   task automatic get(input string nm, input logic [15:0] e,
                      input logic eo, input logic eu);
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (valid_out) begin
            got = 1;
            chk({nm, "_val"}, 32'(filter_out), 32'(e));
            chk({nm, "_ov"}, 32'(overflow), 32'(eo));
            chk({nm, "_un"}, 32'(underflow), 32'(eu));
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no valid_out want pulse", nm);
      end
   endtask

   initial begin
      vec_t        tv[8];
      logic [15:0] r1, rm3;
      logic [15:0] expq[$];
      int          sent, pulses;

`ifdef FRAC_INTERP_CONV_ROUND_EN
      r1  = 16'h0000;
      rm3 = 16'hFFFE;
`else
      r1  = 16'h0001;
      rm3 = 16'hFFFF;
`endif
      tv[0] = '{20'h40000, 20'h20000, 20'h10000,
                16'h4000, 16'h4000, 16'h1000, 1'b0, 1'b0};
      tv[1] = '{20'h7FFFF, 20'h0, 20'h0,
                16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
      tv[2] = '{20'h7FFFF, 20'h0, 20'h0,
                16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1};
      tv[3] = '{20'h20000, 20'h0, 20'h0,
                16'h0001, r1, 16'h0000, 1'b0, 1'b0};
      tv[4] = '{20'h20000, 20'h0, 20'h0,
                16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0};
      tv[5] = '{20'h20000, 20'h0, 20'h0,
                16'hFFFD, rm3, 16'h0000, 1'b0, 1'b0};
      tv[6] = '{20'h40000, 20'h0, 20'hC0000,
                16'h1234, 16'h1234, 16'hEDCC, 1'b0, 1'b0};
      tv[7] = '{20'h20000, 20'h0, 20'h0,
                16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready_in), 32'd1);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_out", 32'(filter_out), 32'h0);
      chk("rst_ov", 32'(overflow), 32'd0);
      chk("rst_un", 32'(underflow), 32'd0);

      // impulse with exact handshake timing
      wr(7'd0, 20'h40000);
      wr(7'd1, 20'h20000);
      wr(7'd2, 20'h10000);
      @(negedge clk);
      chk("imp_rdy0", 32'(ready_in), 32'd1);
      valid_in  = 1'b1;
      filter_in = 16'h4000;
      @(negedge clk);
      valid_in = 1'b0;
      chk("imp_rdy1", 32'(ready_in), 32'd0);
      chk("imp_lat", 32'(valid_out), 32'd0);
      @(negedge clk);
      chk("imp_rdy2", 32'(ready_in), 32'd0);
      chk("imp_v0", 32'(valid_out), 32'd1);
      chk("imp_o0", 32'(filter_out), 32'h4000);
      @(negedge clk);
      chk("imp_rdy3", 32'(ready_in), 32'd1);
      chk("imp_v1", 32'(valid_out), 32'd1);
      chk("imp_o1", 32'(filter_out), 32'h1000);
      valid_in  = 1'b1;
      filter_in = 16'h0000;
      @(negedge clk);
      valid_in = 1'b0;
      chk("imp_rdy4", 32'(ready_in), 32'd0);
      chk("imp_gap", 32'(valid_out), 32'd0);
      @(negedge clk);
      chk("imp_rdy5", 32'(ready_in), 32'd1);
      chk("imp_v2", 32'(valid_out), 32'd1);
      chk("imp_o2", 32'(filter_out), 32'h0000);
      send(16'h0000);
      get("imp_o3", 16'h0000, 1'b0, 1'b0);
      get("imp_o4", 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         wr(7'd0, tv[i].h0);
         wr(7'd1, tv[i].h1);
         wr(7'd2, tv[i].h2);
         send(tv[i].x);
         get($sformatf("vec%0d_p0", i), tv[i].e0, tv[i].ov, tv[i].un);
         get($sformatf("vec%0d_p2", i), tv[i].e1, 1'b0, 1'b0);
      end

      // sustained stream: phase order 0,2,1
      wr(7'd0, 20'h40000);
      wr(7'd1, 20'h20000);
      wr(7'd2, 20'h10000);
      for (int k = 0; k < 20; k++) begin
         logic [15:0] s;
         s = 16'((k + 1) * 256);
         if (k % 2 == 0) begin
            expq.push_back(s);
            expq.push_back(s >> 2);
         end else begin
            expq.push_back(s >> 1);
         end
      end
      sent   = 0;
      pulses = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (valid_out) begin
            pulses++;
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rate_extra: got %h want no pulse",
                        filter_out);
            end else begin
               chk("rate_out", 32'(filter_out), 32'(expq.pop_front()));
            end
         end
         if (sent < 20) begin
            valid_in  = 1'b1;
            filter_in = 16'((sent + 1) * 256);
            if (ready_in) sent++;
         end else begin
            valid_in = 1'b0;
         end
      end
      valid_in = 1'b0;
      chk("rate_pulses", 32'(pulses), 32'd30);
      chk("rate_sent", 32'(sent), 32'd20);

      // coefficient write aborts an EMIT and flushes history
      wr(7'd3, 20'h40000);
      @(negedge clk);
      valid_in  = 1'b1;
      filter_in = 16'h2000;
      @(negedge clk);
      valid_in    = 1'b0;
      coeff_wr_en = 1'b1;
      coeff_addr  = 7'd127;
      coeff_data  = 20'h12345;
      #1;
      chk("abort_rdy", 32'(ready_in), 32'd0);
      @(negedge clk);
      coeff_wr_en = 1'b0;
      chk("abort_valid", 32'(valid_out), 32'd0);
      chk("abort_out", 32'(filter_out), 32'h0);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (valid_out) pulses++;
      end
      chk("abort_quiet", 32'(pulses), 32'd0);
      send(16'h0100);
      get("flush_p0", 16'h0100, 1'b0, 1'b0);
      get("flush_p2", 16'h0040, 1'b0, 1'b0);

      // reset in the middle of an EMIT burst
      wr(7'd0, 20'h40000);
      send(16'h4000);
      @(negedge clk);
      chk("mid_v", 32'(valid_out), 32'd1);
      chk("mid_o", 32'(filter_out), 32'h4000);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(valid_out), 32'd0);
      chk("mrst_out", 32'(filter_out), 32'h0);
      chk("mrst_ov", 32'(overflow), 32'd0);
      chk("mrst_un", 32'(underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_ready", 32'(ready_in), 32'd1);
      send(16'h4000);
      get("post_p0", 16'h0000, 1'b0, 1'b0);
      get("post_p2", 16'h0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
